// File: rtl/harmonic_note_player.sv
// rtl/harmonic_note_player.sv - NUM_HARMONICS-harmonic note player with one shared phase/sine/MAC engine
// Optional build macro: NOTE_PHASE_RESET_EN (load clears phases and aborts the in-flight sample)

module sine_rom (
    input  logic       clk,
    input  logic [9:0] addr,
    output logic [15:0] data
);
    // Quarter-wave table with a parabolic profile x*(2048-x)/32; peaks at 32767 for addr 1023.
    logic [15:0] quarter_wave [1024];

    for (genvar i = 0; i < 1024; i++) begin : g_wave
        assign quarter_wave[i] = 16'((i * (2048 - i)) >> 5);
    end

    always_ff @(posedge clk) begin
        data <= quarter_wave[addr];
    end
endmodule

module frequency_rom #(
    parameter int NOTE_WIDTH = 6
) (
    input  logic                  clk,
    input  logic [NOTE_WIDTH-1:0] note,
    output logic [19:0]           step
);
    localparam int DEPTH = 1 << NOTE_WIDTH;

    // Equal-tempered steps for a 22-bit phase at 48 kHz; note 1 is A0 (27.5 Hz).
    function automatic logic [19:0] base_step(input int semitone);
        case (semitone)
            0:       return 20'd2403;
            1:       return 20'd2546;
            2:       return 20'd2697;
            3:       return 20'd2858;
            4:       return 20'd3028;
            5:       return 20'd3208;
            6:       return 20'd3398;
            7:       return 20'd3600;
            8:       return 20'd3815;
            9:       return 20'd4041;
            10:      return 20'd4282;
            default: return 20'd4536;
        endcase
    endfunction

    logic [19:0] steps [DEPTH];

    for (genvar n = 0; n < DEPTH; n++) begin : g_steps
        if (n == 0) begin : g_rest
            assign steps[n] = 20'd0;
        end else begin : g_note
            assign steps[n] = base_step((n - 1) % 12) << ((n - 1) / 12);
        end
    end

    always_ff @(posedge clk) begin
        step <= steps[note];
    end
endmodule

module harmonic_note_player #(
    parameter int NUM_HARMONICS = 3,
    parameter int NOTE_WIDTH    = 6,
    parameter int DUR_WIDTH     = 6,
    parameter int PHASE_WIDTH   = 22
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         play_enable,
    input  logic [NOTE_WIDTH-1:0]        note_to_load,
    input  logic [DUR_WIDTH-1:0]         duration_to_load,
    input  logic                         load_new_note,
    input  logic                         beat,
    input  logic [4*NUM_HARMONICS-1:0]   harmonic_gains,
    input  logic                         generate_next_sample,
    output logic signed [15:0]           sample_out,
    output logic                         new_sample_ready,
    output logic                         playing,
    output logic                         done_with_note
);
    localparam int IDX_W = (NUM_HARMONICS > 1) ? $clog2(NUM_HARMONICS) : 1;
    localparam int ACC_W = 16 + 3 + 4;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);

`ifdef NOTE_PHASE_RESET_EN
    localparam bit PHASE_RESET_ON_LOAD = 1'b1;
`else
    localparam bit PHASE_RESET_ON_LOAD = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

    state_t state, next_state;

    logic [NOTE_WIDTH-1:0]     note_reg;
    logic [19:0]               step;
    logic [DUR_WIDTH-1:0]      dur_count;
    logic [PHASE_WIDTH-1:0]    phase [NUM_HARMONICS];
    logic [PHASE_WIDTH-1:0]    step_lat;
    logic [PHASE_WIDTH-1:0]    mult;
    logic [IDX_W-1:0]          h_idx;
    logic                      last_issue;
    logic                      abort;
    logic [1:0]                quadrant;
    logic [9:0]                rom_addr;
    logic [15:0]               rom_data;
    logic                      neg_d;
    logic [3:0]                gain_d;
    logic                      mac_valid;
    logic signed [15:0]        sine_s;
    logic signed [20:0]        mac_prod;
    logic signed [ACC_W-1:0]   mac_term;
    logic signed [ACC_W-1:0]   acc;
    logic signed [15:0]        sat_value;

    assign abort          = PHASE_RESET_ON_LOAD && load_new_note;
    assign done_with_note = (dur_count == '0);
    assign last_issue     = (h_idx == IDX_W'(NUM_HARMONICS - 1));

    frequency_rom #(.NOTE_WIDTH(NOTE_WIDTH)) u_frequency_rom (
        .clk  (clk),
        .note (note_reg),
        .step (step)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            note_reg  <= '0;
            dur_count <= '0;
            playing   <= 1'b0;
        end else if (load_new_note) begin
            note_reg  <= note_to_load;
            dur_count <= duration_to_load;
            playing   <= (duration_to_load != '0);
        end else if (beat && play_enable && dur_count != '0) begin
            dur_count <= dur_count - 1'b1;
            if (dur_count == DUR_WIDTH'(1)) begin
                playing <= 1'b0;
            end
        end
    end

    // Quadrant folding: odd quadrants mirror the address, the upper half-cycle negates.
    assign quadrant = phase[h_idx][PHASE_WIDTH-1 -: 2];
    assign rom_addr = quadrant[0] ? ~phase[h_idx][PHASE_WIDTH-3 -: 10]
                                  :  phase[h_idx][PHASE_WIDTH-3 -: 10];

    sine_rom u_sine_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    assign sine_s   = neg_d ? -$signed(rom_data) : $signed(rom_data);
    assign mac_prod = 21'(sine_s) * 21'($signed({1'b0, gain_d}));
    assign mac_term = ACC_W'(mac_prod) >>> 4;

    always_comb begin
        sat_value = acc[15:0];
        if (acc > SAT_MAX) begin
            sat_value = 16'sh7FFF;
        end else if (acc < SAT_MIN) begin
            sat_value = 16'sh8000;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (generate_next_sample && play_enable) next_state = ISSUE;
            ISSUE:   if (last_issue) next_state = DRAIN;
            DRAIN:   next_state = OUT;
            OUT:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort) begin
            next_state = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            step_lat         <= '0;
            mult             <= '0;
            h_idx            <= '0;
            acc              <= '0;
            mac_valid        <= 1'b0;
            neg_d            <= 1'b0;
            gain_d           <= '0;
            sample_out       <= '0;
            new_sample_ready <= 1'b0;
            for (int i = 0; i < NUM_HARMONICS; i++) begin
                phase[i] <= '0;
            end
        end else begin
            mac_valid        <= (state == ISSUE) && !abort;
            neg_d            <= quadrant[1];
            gain_d           <= harmonic_gains[{h_idx, 2'b00} +: 4];
            new_sample_ready <= (state == OUT) && !abort;

            if (state == OUT && !abort) begin
                sample_out <= playing ? sat_value : 16'sd0;
            end

            // The step is captured at the request, so a mid-sample load only affects the next sample.
            if (state == IDLE) begin
                acc      <= '0;
                mult     <= PHASE_WIDTH'(step);
                step_lat <= PHASE_WIDTH'(step);
                h_idx    <= '0;
            end else begin
                if (mac_valid) begin
                    acc <= acc + mac_term;
                end
                if (state == ISSUE) begin
                    mult  <= mult + step_lat;
                    h_idx <= h_idx + 1'b1;
                end
            end

            for (int i = 0; i < NUM_HARMONICS; i++) begin
                if (abort) begin
                    phase[i] <= '0;
                end else if (state == ISSUE && playing && h_idx == IDX_W'(i)) begin
                    phase[i] <= phase[i] + mult;
                end
            end
        end
    end
endmodule

// File: tb/tb_harmonic_note_player.sv
// tb/tb_harmonic_note_player.sv - directed self-checking bench for harmonic_note_player

module tb_harmonic_note_player;
    localparam int N = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              play_enable;
    logic [5:0]        note_to_load;
    logic [5:0]        duration_to_load;
    logic              load_new_note;
    logic              beat;
    logic [4*N-1:0]    harmonic_gains;
    logic              generate_next_sample;
    logic signed [15:0] sample_out;
    logic              new_sample_ready;
    logic              playing;
    logic              done_with_note;

    int checks = 0;
    int passed = 0;
    int ph [N];

    harmonic_note_player dut (
        .clk                  (clk),
        .reset                (reset),
        .play_enable          (play_enable),
        .note_to_load         (note_to_load),
        .duration_to_load     (duration_to_load),
        .load_new_note        (load_new_note),
        .beat                 (beat),
        .harmonic_gains       (harmonic_gains),
        .generate_next_sample (generate_next_sample),
        .sample_out           (sample_out),
        .new_sample_ready     (new_sample_ready),
        .playing              (playing),
        .done_with_note       (done_with_note)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int note, input int dur);
        note_to_load     = 6'(note);
        duration_to_load = 6'(dur);
        load_new_note    = 1'b1;
        tick();
        load_new_note    = 1'b0;
        tick();
        tick();
    endtask

    task automatic request(output int lat);
        generate_next_sample = 1'b1;
        tick();
        generate_next_sample = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (new_sample_ready) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic count_strobes(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (new_sample_ready) n++;
        end
    endtask

    function automatic int sine_model(input int p);
        int q, a, v;
        q = (p >> 20) & 3;
        a = (p >> 10) & 1023;
        if (q == 1 || q == 3) a = 1023 - a;
        v = (a * (2048 - a)) >> 5;
        if (q >= 2) v = -v;
        return v;
    endfunction

    task automatic model_sample(input int s, input logic [4*N-1:0] g, input bit live, output int y);
        int sum;
        sum = 0;
        for (int h = 0; h < N; h++) begin
            sum += (sine_model(ph[h]) * int'(g[4*h +: 4])) >>> 4;
            if (live) ph[h] = (ph[h] + (h + 1) * s) & 32'h3FFFFF;
        end
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
        y = live ? sum : 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, y, n;

        reset = 1'b0; play_enable = 1'b1; note_to_load = '0; duration_to_load = '0;
        load_new_note = 1'b0; beat = 1'b0; harmonic_gains = '0; generate_next_sample = 1'b0;
        for (int h = 0; h < N; h++) ph[h] = 0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        check("reset sample_out", sample_out, 0);
        check("reset ready", new_sample_ready, 0);
        check("reset playing", playing, 0);
        check("reset done", done_with_note, 1);

        // Rest note: strobe after N+2 cycles with a zero sample, then 5 beats end it.
        load(0, 5);
        harmonic_gains = 12'hFFF;
        check("rest playing", playing, 1);
        check("rest done", done_with_note, 0);
        request(lat);
        check("rest latency", lat, N + 2);
        check("rest sample", sample_out, 0);
        tick();
        check("rest strobe width", new_sample_ready, 0);
        for (int b = 1; b <= 5; b++) begin
            beat = 1'b1; tick(); beat = 1'b0; tick();
            if (b == 4) check("rest playing at 4 beats", playing, 1);
        end
        check("rest playing end", playing, 0);
        check("rest done end", done_with_note, 1);

        // Note 20 (step 7200), fundamental only at gain 15.
        load(20, 3);
        harmonic_gains = 12'h00F;
        for (int k = 0; k < 40; k++) begin
            request(lat);
            check("h1 latency", lat, N + 2);
            model_sample(7200, harmonic_gains, 1'b1, y);
            check("h1 sample", sample_out, y);
        end
        check("h1 phase", dut.phase[0], 40 * 7200);

        // Reset during ISSUE.
        generate_next_sample = 1'b1; tick(); generate_next_sample = 1'b0; tick();
        reset = 1'b0; tick(); reset = 1'b1;
        check("midreset sample_out", sample_out, 0);
        check("midreset ready", new_sample_ready, 0);
        check("midreset playing", playing, 0);
        check("midreset state", dut.state, 0);
        count_strobes(10, n);
        check("midreset no strobe", n, 0);
        for (int h = 0; h < N; h++) ph[h] = 0;

        // Note 63 (step 86304), all gains 15: saturation both ways.
        load(63, 10);
        harmonic_gains = 12'hFFF;
        for (int k = 0; k < 46; k++) begin
            request(lat);
            check("sat latency", lat, N + 2);
            model_sample(86304, harmonic_gains, 1'b1, y);
            check("sat sample", sample_out, y);
            if (k == 4) check("sat positive", sample_out, 32767);
            if (k == 45) check("sat negative", sample_out, -32768);
        end

        // Load and beat together; then frozen beats and requests.
        note_to_load = 6'd20; duration_to_load = 6'd4; load_new_note = 1'b1; beat = 1'b1;
        tick();
        load_new_note = 1'b0; beat = 1'b0;
        check("load beats beat", dut.dur_count, 4);
        check("load beat playing", playing, 1);
        play_enable = 1'b0;
        for (int b = 0; b < 3; b++) begin
            beat = 1'b1; tick(); beat = 1'b0; tick();
        end
        check("frozen count", dut.dur_count, 4);
        generate_next_sample = 1'b1; tick(); generate_next_sample = 1'b0;
        count_strobes(10, n);
        check("frozen no strobe", n, 0);
        check("frozen sample hold", sample_out, -32768);
        play_enable = 1'b1;
        beat = 1'b1; tick(); beat = 1'b0; tick();
        check("resumed count", dut.dur_count, 3);

        // Back-to-back requests give a single strobe.
        generate_next_sample = 1'b1; tick(); tick(); generate_next_sample = 1'b0;
        count_strobes(12, n);
        check("dropped request", n, 1);

        // Load in the middle of a sample.
        generate_next_sample = 1'b1; tick(); generate_next_sample = 1'b0; tick();
        note_to_load = 6'd5; duration_to_load = 6'd7; load_new_note = 1'b1; tick(); load_new_note = 1'b0;
        check("midload count", dut.dur_count, 7);
        count_strobes(10, n);
`ifdef NOTE_PHASE_RESET_EN
        check("midload aborted", n, 0);
        for (int h = 0; h < N; h++) check("midload phase", dut.phase[h], 0);
`else
        check("midload completes", n, 1);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/harmonic_note_player.md
Name: harmonic_note_player

Overview:
Parametrised successor to the three-voice note player. Plays one note as NUM_HARMONICS integer harmonics (f, 2f, 3f, …) with run-time per-harmonic 4-bit gains. A single time-multiplexed phase/sine engine replaces one sine reader per voice. The beat-driven duration counter and the playing/done status go to the note distributor; samples go to the codec through the existing generate/ready handshake.

Parameters:
NUM_HARMONICS, 3, harmonics summed, 1..8
NOTE_WIDTH, 6, note index width into frequency_rom
DUR_WIDTH, 6, duration counter width in beats
PHASE_WIDTH, 22, phase accumulator width; top 12 bits address the sine table

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
play_enable  in  1  high: counter runs and samples are generated; low: freeze
note_to_load  in  NOTE_WIDTH  note index; 0 = rest
duration_to_load  in  DUR_WIDTH  note length in beats
load_new_note  in  1  one-cycle load strobe
beat  in  1  one-cycle 1/48 s tick
harmonic_gains  in  4*NUM_HARMONICS  gain of harmonic h at bits [4h-1:4h-4], h=1..N
generate_next_sample  in  1  one-cycle codec request
sample_out  out  16  signed sample
new_sample_ready  out  1  one-cycle strobe; sample_out valid from this cycle
playing  out  1  note active
done_with_note  out  1  duration counter is zero

Behaviour:
- Reset (reset==0 at clk edge) clears:
  - note register, duration counter, all phases, sample_out, new_sample_ready, playing.
  - The engine returns to IDLE. Reset wins over every other input.
- Note register: on load_new_note, latch note_to_load. This drives frequency_rom (1-cycle read) to produce step[19:0].
- Duration counter:
  - On load_new_note, load duration_to_load.
  - Otherwise, on beat && play_enable && count!=0, decrement by 1.
  - Load beats a simultaneous beat.
  - done_with_note = (count==0), combinational.
  - playing is set on load when duration_to_load!=0; it clears on the cycle count reaches 0.
  - A load with duration 0 gives playing=0 and done_with_note=1 immediately.
- Engine FSM IDLE -> ISSUE -> DRAIN -> OUT -> IDLE:
  - IDLE: accept generate_next_sample only when play_enable=1. Clear the accumulator. Set mult=step and h=1.
  - ISSUE (N cycles, h=1..N):
    - Drive the sine address from phase_h.
    - Update phase_h <= phase_h + mult, mod 2^PHASE_WIDTH, but only when playing=1.
    - Then mult <= mult + step, so harmonic h advances by h*step.
  - The sine table is quarter-wave sine_rom with 1-cycle latency. Phase bits [21:20] are the quadrant and [19:10] the address.
    - Quadrants 1 and 3 use address ~addr.
    - Quadrants 2 and 3 negate the output.
  - MAC, one cycle behind ISSUE: acc += (sine_h * gain_h) >>> 4. Signed; acc is 16+3+4 bits wide.
  - DRAIN: absorb the last ROM read.
  - OUT:
    - sample_out <= saturate(acc) to [-32768, 32767]. If playing=0, sample_out <= 0 instead.
    - Pulse new_sample_ready for 1 cycle.
  - Latency: new_sample_ready asserts exactly NUM_HARMONICS+2 cycles after the request edge.
- Request rules:
  - A generate_next_sample outside IDLE is dropped. No queueing.
  - A request in IDLE with play_enable=0 is ignored. No strobe, and sample_out holds.
- load_new_note mid-computation: the note and counter update at once. The current sample finishes with the step already captured, and ROM step changes take effect at the next request.
- Gains are sampled per harmonic during ISSUE. A gain of 0 removes that harmonic.

Optional Feature:
NOTE_PHASE_RESET_EN.
- Defined: load_new_note clears every phase accumulator, giving a deterministic attack, and the engine aborts any in-flight sample to IDLE without a strobe.
- Undefined: phases run continuously across note changes, and in-flight samples complete.

Test Plan:
- Reset mid-ISSUE (reset=0 one cycle) -> next cycle sample_out=0, new_sample_ready=0, playing=0, FSM IDLE; no strobe follows.
- Load note 0 (rest), duration 5, gains all 0xF, request -> strobe at cycle N+2 (5 for N=3), sample_out=0; after 5 beats, playing=0 and done_with_note=1.
- Load note 20, duration 3, gains {0,0,0xF}, 40 requests -> each sample matches the bench model of sine(phase_1)*15>>>4; phase_1 advances by step(20) per request.
- All gains 0xF, phases near quadrant-0 peak, N=8 build -> summed value above 32767 saturates to exactly 32767; negative peak saturates to -32768.
- load_new_note and beat in the same cycle, duration 4 -> count=4, not 3; play_enable=0 during 3 beats -> count unchanged and requests produce no strobe.
- Second request one cycle after the first -> exactly one strobe. With NOTE_PHASE_RESET_EN, a load mid-sample -> no strobe, and all phases read 0.
